vbuf_arbiter: RTL and testbench
===============================

Name: vbuf_arbiter

Overview:
- Single-port Avalon-MM burst arbiter in front of the 128-bit vbuf DDR port.
- Shares the port between the output-fetch read master (scaler/HDMI path) and the input-capture write master.
- Replaces ad-hoc op_split/reading/writing interlocks with an explicit FSM: round-robin, read-urgency priority and a write-starvation limit.
- Bursts are never interleaved: a read burst holds the port until its last readdatavalid beat.

Parameters:
- MAX_RD_STREAK, 4, max consecutive read grants while a write is pending before a write is forced (1..15).
- BCW, 8, burstcount width.

Ports:
- clk_vbuf  in  1  Sole clock; everything is synchronous to its rising edge.
- reset_n  in  1  Synchronous, active-low reset.
- rd_address  in  28  Read master word address.
- rd_burstcount  in  BCW  Read burst length.
- rd_read  in  1  Read request.
- rd_waitrequest  out  1  Stall to read master.
- rd_readdata  out  128  Pass-through of vbuf_readdata.
- rd_readdatavalid  out  1  Pass-through of vbuf_readdatavalid.
- rd_urgent  in  1  Read FIFO below low-water mark; raises read priority.
- wr_address  in  28  Write master address.
- wr_burstcount  in  BCW  Write burst length.
- wr_writedata  in  128  Write data.
- wr_byteenable  in  16  Write byte enables.
- wr_write  in  1  Write request/beat valid.
- wr_waitrequest  out  1  Stall to write master.
- vbuf_address  out  28  To DDR.
- vbuf_burstcount  out  BCW  To DDR.
- vbuf_read  out  1  To DDR.
- vbuf_write  out  1  To DDR.
- vbuf_writedata  out  128  To DDR.
- vbuf_byteenable  out  16  To DDR.
- vbuf_waitrequest  in  1  From DDR.
- vbuf_readdata  in  128  From DDR.
- vbuf_readdatavalid  in  1  From DDR.
- grant_rd  out  1  FSM in RD_CMD or RD_WAIT.
- grant_wr  out  1  FSM in WR_BURST.

Behaviour:
- States: IDLE, RD_CMD, RD_WAIT, WR_BURST. Reset (reset_n=0 at clock edge) -> IDLE; beat counter=0, rd_streak=0, last_grant=WR.
- Reset outputs: vbuf_read=0, vbuf_write=0, grant_*=0, rd/wr_waitrequest=1.
- Master-side outputs are a combinational mux of the granted requester.
- vbuf_read is driven only in RD_CMD; vbuf_write only in WR_BURST. In all other states both are 0.
- The non-granted requester always sees waitrequest=1. The granted one sees vbuf_waitrequest.
- rd_readdata/rd_readdatavalid are forwarded unconditionally in every state, including during and after reset.
- IDLE arbitration (registered, 1-cycle latency from request to grant):
  - Only rd_read -> RD_CMD. Only wr_write -> WR_BURST.
  - Both pending: if wr pending and rd_streak==MAX_RD_STREAK -> WR_BURST.
  - Else if rd_urgent -> RD_CMD.
  - Else the opposite of last_grant.
  - On a read grant with wr_write pending, rd_streak++ (saturating). On any write grant, rd_streak=0.
- RD_CMD:
  - On the cycle rd_read & ~vbuf_waitrequest: load beat counter = rd_burstcount (0 treated as 1) -> RD_WAIT.
  - If rd_read drops before acceptance -> IDLE, no counter load.
- RD_WAIT: decrement the counter on each vbuf_readdatavalid. On the beat where counter==1 -> IDLE. No new command is issued while in RD_WAIT.
- WR_BURST:
  - The first accepted beat (wr_write & ~vbuf_waitrequest) loads counter = wr_burstcount-1 (0 treated as 1).
  - Each further accepted beat decrements the counter. The last beat returns to IDLE the same cycle.
  - wr_write low mid-burst is a legal bubble: stay in WR_BURST, vbuf_write=0.
  - Address/burstcount are taken from wr_* on the first beat only and are held in a register for the rest of the burst.
- readdatavalid seen while not in RD_WAIT (e.g. after reset mid-burst) is forwarded but not counted.
- A single-beat burst from either side takes 1 arbitration cycle plus 1 transfer cycle. Back-to-back bursts cost 1 IDLE cycle between them.

Test Plan:
1. Read only: rd_read, addr 0x0200000, burst 64, DDR returns 64 beats -> one vbuf_read pulse; grant_rd high until the 64th beat; IDLE the next cycle; 64 rd_readdatavalid.
2. Write only: burst 4 with a 2-cycle wr_write gap after beat 2 -> vbuf_write asserted for exactly 4 beats; address held; IDLE after beat 4.
3. Both pending continuously, rd_urgent=0 -> grant sequence R,W,R,W (first grant R since last_grant=WR after reset).
4. Both pending, rd_urgent=1, MAX_RD_STREAK=4 -> grants R,R,R,R,W,R,...; rd_streak cleared on W.
5. Reset mid-RD_WAIT after 10 of 64 beats -> IDLE next cycle, vbuf_read/write=0. The remaining 54 beats still appear on rd_readdatavalid. A write is granted within 2 cycles of reset release.
6. vbuf_waitrequest held high 20 cycles in RD_CMD -> vbuf_read and address stable; rd_waitrequest=1 throughout; wr_waitrequest=1.

Source files
------------

// File: rtl/vbuf_arbiter_if.sv
// Avalon-MM bundle around the vbuf arbiter: read master, write master and DDR port.
// slave = arbiter view, master = the surrounding masters and DDR model.
interface vbuf_arbiter_if #(
  parameter int BCW = 8
);
  logic [27:0]    rd_address;
  logic [BCW-1:0] rd_burstcount;
  logic           rd_read;
  logic           rd_waitrequest;
  logic [127:0]   rd_readdata;
  logic           rd_readdatavalid;
  logic           rd_urgent;

  logic [27:0]    wr_address;
  logic [BCW-1:0] wr_burstcount;
  logic [127:0]   wr_writedata;
  logic [15:0]    wr_byteenable;
  logic           wr_write;
  logic           wr_waitrequest;

  logic [27:0]    vbuf_address;
  logic [BCW-1:0] vbuf_burstcount;
  logic           vbuf_read;
  logic           vbuf_write;
  logic [127:0]   vbuf_writedata;
  logic [15:0]    vbuf_byteenable;
  logic           vbuf_waitrequest;
  logic [127:0]   vbuf_readdata;
  logic           vbuf_readdatavalid;

  logic           grant_rd;
  logic           grant_wr;

  modport slave (
    input  rd_address, rd_burstcount, rd_read, rd_urgent,
    input  wr_address, wr_burstcount, wr_writedata, wr_byteenable, wr_write,
    input  vbuf_waitrequest, vbuf_readdata, vbuf_readdatavalid,
    output rd_waitrequest, rd_readdata, rd_readdatavalid, wr_waitrequest,
    output vbuf_address, vbuf_burstcount, vbuf_read, vbuf_write,
    output vbuf_writedata, vbuf_byteenable, grant_rd, grant_wr
  );

  modport master (
    output rd_address, rd_burstcount, rd_read, rd_urgent,
    output wr_address, wr_burstcount, wr_writedata, wr_byteenable, wr_write,
    output vbuf_waitrequest, vbuf_readdata, vbuf_readdatavalid,
    input  rd_waitrequest, rd_readdata, rd_readdatavalid, wr_waitrequest,
    input  vbuf_address, vbuf_burstcount, vbuf_read, vbuf_write,
    input  vbuf_writedata, vbuf_byteenable, grant_rd, grant_wr
  );
endinterface

// File: rtl/vbuf_arbiter.sv
// Round-robin read/write burst arbiter for the vbuf DDR port; 1-cycle registered grant,
// command path combinational; non-granted master is stalled, granted master sees DDR waitrequest.
module vbuf_arbiter #(
  parameter int MAX_RD_STREAK = 4,
  parameter int BCW           = 8
) (
  input  logic           clk_vbuf,
  input  logic           reset_n,
  vbuf_arbiter_if.slave  bus
);
  typedef enum logic [1:0] {IDLE, RD_CMD, RD_WAIT, WR_BURST} state_t;

  localparam logic [3:0]     STREAK_MAX = 4'(MAX_RD_STREAK);
  localparam logic [BCW-1:0] ONE        = BCW'(1);

  state_t         state_q, state_d;
  logic [BCW-1:0] cnt_q, cnt_d;
  logic [3:0]     rd_streak_q, rd_streak_d;
  logic           last_wr_q, last_wr_d;
  logic           wr_started_q, wr_started_d;
  logic [27:0]    wr_addr_q, wr_addr_d;
  logic [BCW-1:0] wr_bc_q, wr_bc_d;

  logic rd_acc, wr_acc, pick_wr;

  assign rd_acc = bus.rd_read & ~bus.vbuf_waitrequest;
  assign wr_acc = bus.wr_write & ~bus.vbuf_waitrequest;

  always_ff @(posedge clk_vbuf) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      rd_streak_q  <= '0;
      last_wr_q    <= 1'b1;
      wr_started_q <= 1'b0;
      wr_addr_q    <= '0;
      wr_bc_q      <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      rd_streak_q  <= rd_streak_d;
      last_wr_q    <= last_wr_d;
      wr_started_q <= wr_started_d;
      wr_addr_q    <= wr_addr_d;
      wr_bc_q      <= wr_bc_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    rd_streak_d  = rd_streak_q;
    last_wr_d    = last_wr_q;
    wr_started_d = wr_started_q;
    wr_addr_d    = wr_addr_q;
    wr_bc_d      = wr_bc_q;
    pick_wr      = 1'b0;

    case (state_q)
      IDLE: begin
        // Starvation limit beats urgency; otherwise alternate with the last winner.
        if (bus.rd_read && bus.wr_write) begin
          if (rd_streak_q == STREAK_MAX) pick_wr = 1'b1;
          else if (bus.rd_urgent)        pick_wr = 1'b0;
          else                           pick_wr = ~last_wr_q;
        end else begin
          pick_wr = bus.wr_write;
        end

        if (bus.rd_read || bus.wr_write) begin
          if (pick_wr) begin
            state_d      = WR_BURST;
            rd_streak_d  = '0;
            last_wr_d    = 1'b1;
            wr_started_d = 1'b0;
          end else begin
            state_d   = RD_CMD;
            last_wr_d = 1'b0;
            if (bus.wr_write && rd_streak_q != 4'hF) rd_streak_d = rd_streak_q + 4'd1;
          end
        end
      end

      RD_CMD: begin
        if (rd_acc) begin
          cnt_d   = (bus.rd_burstcount == '0) ? ONE : bus.rd_burstcount;
          state_d = RD_WAIT;
        end else if (!bus.rd_read) begin
          state_d = IDLE;
        end
      end

      RD_WAIT: begin
        if (bus.vbuf_readdatavalid) begin
          cnt_d = cnt_q - ONE;
          if (cnt_q <= ONE) state_d = IDLE;
        end
      end

      WR_BURST: begin
        if (wr_acc) begin
          if (!wr_started_q) begin
            wr_addr_d    = bus.wr_address;
            wr_bc_d      = bus.wr_burstcount;
            wr_started_d = 1'b1;
            cnt_d        = (bus.wr_burstcount <= ONE) ? '0 : bus.wr_burstcount - ONE;
            if (bus.wr_burstcount <= ONE) begin
              state_d      = IDLE;
              wr_started_d = 1'b0;
            end
          end else begin
            cnt_d = cnt_q - ONE;
            if (cnt_q <= ONE) begin
              state_d      = IDLE;
              wr_started_d = 1'b0;
            end
          end
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    bus.rd_waitrequest  = 1'b1;
    bus.wr_waitrequest  = 1'b1;
    bus.vbuf_read       = 1'b0;
    bus.vbuf_write      = 1'b0;
    bus.vbuf_address    = '0;
    bus.vbuf_burstcount = '0;
    bus.vbuf_byteenable = '0;
    bus.vbuf_writedata  = bus.wr_writedata;
    bus.grant_rd        = 1'b0;
    bus.grant_wr        = 1'b0;

    case (state_q)
      RD_CMD: begin
        bus.grant_rd        = 1'b1;
        bus.vbuf_read       = bus.rd_read;
        bus.rd_waitrequest  = bus.vbuf_waitrequest;
        bus.vbuf_address    = bus.rd_address;
        bus.vbuf_burstcount = bus.rd_burstcount;
      end
      RD_WAIT: bus.grant_rd = 1'b1;
      WR_BURST: begin
        bus.grant_wr        = 1'b1;
        bus.vbuf_write      = bus.wr_write;
        bus.wr_waitrequest  = bus.vbuf_waitrequest;
        // Command fields come live on the first beat, from the latch afterwards.
        bus.vbuf_address    = wr_started_q ? wr_addr_q : bus.wr_address;
        bus.vbuf_burstcount = wr_started_q ? wr_bc_q   : bus.wr_burstcount;
        bus.vbuf_byteenable = bus.wr_byteenable;
      end
      default: ;
    endcase
  end

  assign bus.rd_readdata      = bus.vbuf_readdata;
  assign bus.rd_readdatavalid = bus.vbuf_readdatavalid;
endmodule

// File: tb/tb_vbuf_arbiter.sv
// Directed bench for vbuf_arbiter: per-cycle vector table plus multi-cycle burst sequences.
module tb_vbuf_arbiter;
  localparam int BCW = 8;

  logic clk_vbuf = 1'b0;
  logic reset_n  = 1'b0;
  always #5 clk_vbuf = ~clk_vbuf;

  vbuf_arbiter_if #(.BCW(BCW)) bus ();

  vbuf_arbiter #(.MAX_RD_STREAK(4), .BCW(BCW)) dut (
    .clk_vbuf (clk_vbuf),
    .reset_n  (reset_n),
    .bus      (bus)
  );

  int checks   = 0;
  int failures = 0;

  // Inputs: rst_n rr urg ww vw rdv | expected: g_rd g_wr v_rd v_wr rd_wt wr_wt
  typedef struct packed {
    logic rst_n, rr, urg, ww, vw, rdv;
    logic g_rd, g_wr, v_rd, v_wr, rd_wt, wr_wt;
  } vec_t;

  vec_t tbl [18];

  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic chkw(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_vbuf);
    #1;
  endtask

  task automatic half();
    @(negedge clk_vbuf);
  endtask

  task automatic idle_inputs();
    bus.rd_address         = '0;
    bus.rd_burstcount      = 8'd1;
    bus.rd_read            = 1'b0;
    bus.rd_urgent          = 1'b0;
    bus.wr_address         = '0;
    bus.wr_burstcount      = 8'd1;
    bus.wr_writedata       = '0;
    bus.wr_byteenable      = '0;
    bus.wr_write           = 1'b0;
    bus.vbuf_waitrequest   = 1'b0;
    bus.vbuf_readdata      = '0;
    bus.vbuf_readdatavalid = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset_n = 1'b0;
    step();
    step();
    reset_n = 1'b1;
  endtask

  task automatic run_grants(input logic urg, input string exp, input string name);
    string got;
    got = "";
    do_reset();
    bus.rd_read = 1'b1;
    bus.wr_write = 1'b1;
    bus.rd_urgent = urg;
    bus.vbuf_readdatavalid = 1'b1;
    for (int c = 0; c < 40 && got.len() < 6; c++) begin
      half();
      if (bus.vbuf_read && !bus.rd_waitrequest)  got = {got, "R"};
      if (bus.vbuf_write && !bus.wr_waitrequest) got = {got, "W"};
      step();
    end
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s: got %s expected %s", name, got, exp);
    end
  endtask

  initial begin
    vec_t v;
    int   fwd, bad, cnt, beat;
    logic [5:0]   pat;
    logic [127:0] exp_dat;

    tbl[0]  = 12'b000000_000011;
    tbl[1]  = 12'b110000_000011;
    tbl[2]  = 12'b110010_101011;
    tbl[3]  = 12'b110000_101001;
    tbl[4]  = 12'b100000_100011;
    tbl[5]  = 12'b100001_100011;
    tbl[6]  = 12'b100100_000011;
    tbl[7]  = 12'b100100_010110;
    tbl[8]  = 12'b110100_000011;
    tbl[9]  = 12'b110100_101001;
    tbl[10] = 12'b100101_100011;
    tbl[11] = 12'b010100_000011;
    tbl[12] = 12'b110100_000011;
    tbl[13] = 12'b110110_101011;
    tbl[14] = 12'b010110_101011;
    tbl[15] = 12'b100100_000011;
    tbl[16] = 12'b100100_010110;
    tbl[17] = 12'b100000_000011;

    do_reset();
    for (int i = 0; i < 18; i++) begin
      v = tbl[i];
      reset_n                = v.rst_n;
      bus.rd_read            = v.rr;
      bus.rd_urgent          = v.urg;
      bus.wr_write           = v.ww;
      bus.vbuf_waitrequest   = v.vw;
      bus.vbuf_readdatavalid = v.rdv;
      half();
      chk1($sformatf("vec%0d_grant_rd", i), bus.grant_rd, v.g_rd);
      chk1($sformatf("vec%0d_grant_wr", i), bus.grant_wr, v.g_wr);
      chk1($sformatf("vec%0d_vbuf_read", i), bus.vbuf_read, v.v_rd);
      chk1($sformatf("vec%0d_vbuf_write", i), bus.vbuf_write, v.v_wr);
      chk1($sformatf("vec%0d_rd_wait", i), bus.rd_waitrequest, v.rd_wt);
      chk1($sformatf("vec%0d_wr_wait", i), bus.wr_waitrequest, v.wr_wt);
      chk1($sformatf("vec%0d_rdv_fwd", i), bus.rd_readdatavalid, v.rdv);
      step();
    end

    // 64-beat read with occasional gaps in the returned data
    do_reset();
    bus.rd_address    = 28'h0200000;
    bus.rd_burstcount = 8'd64;
    bus.rd_read       = 1'b1;
    half();
    chk1("rd64_idle_grant", bus.grant_rd, 1'b0);
    step();
    half();
    chk1("rd64_cmd_read", bus.vbuf_read, 1'b1);
    chkw("rd64_cmd_addr", {4'h0, bus.vbuf_address}, 32'h0200000);
    chkw("rd64_cmd_bc", {24'h0, bus.vbuf_burstcount}, 32'd64);
    step();
    bus.rd_read = 1'b0;
    fwd = 0; bad = 0; cnt = 0; beat = 0;
    for (int c = 0; c < 80 && beat < 64; c++) begin
      bus.vbuf_readdatavalid = (c % 9 != 4);
      exp_dat = {96'h0, 32'(c) ^ 32'hA5A50000};
      bus.vbuf_readdata = exp_dat;
      half();
      if (bus.vbuf_read) cnt++;
      if (!bus.grant_rd) bad++;
      if (bus.rd_readdatavalid) fwd++;
      if (bus.rd_readdata !== exp_dat) bad++;
      if (bus.vbuf_readdatavalid) beat++;
      step();
    end
    bus.vbuf_readdatavalid = 1'b0;
    half();
    chk1("rd64_idle_after", bus.grant_rd, 1'b0);
    chkw("rd64_beats_fwd", fwd, 64);
    chkw("rd64_extra_reads", cnt, 0);
    chkw("rd64_hold_or_data_errs", bad, 0);
    step();

    // 4-beat write with a 2-cycle bubble after beat 2; command fields must be held
    do_reset();
    bus.wr_address    = 28'h0123456;
    bus.wr_burstcount = 8'd4;
    bus.wr_byteenable = 16'hF0F0;
    bus.wr_write      = 1'b1;
    half();
    chk1("wr4_idle_grant", bus.grant_wr, 1'b0);
    step();
    pat = 6'b110011;
    cnt = 0; bad = 0;
    for (int k = 0; k < 6; k++) begin
      bus.wr_write     = pat[k];
      bus.wr_writedata = {96'h0, 32'(k) + 32'h100};
      if (k >= 1) begin
        bus.wr_address    = 28'hFFFFFFF;
        bus.wr_burstcount = 8'd9;
      end
      half();
      if (!bus.grant_wr) bad++;
      if (bus.vbuf_write) begin
        cnt++;
        if (bus.vbuf_address !== 28'h0123456) bad++;
        if (bus.vbuf_burstcount !== 8'd4) bad++;
        if (bus.vbuf_byteenable !== 16'hF0F0) bad++;
        if (bus.vbuf_writedata !== {96'h0, 32'(k) + 32'h100}) bad++;
      end
      step();
    end
    bus.wr_write = 1'b0;
    half();
    chk1("wr4_idle_after", bus.grant_wr, 1'b0);
    chkw("wr4_beats", cnt, 4);
    chkw("wr4_hold_errs", bad, 0);
    step();

    run_grants(1'b0, "RWRWRW", "rr_alternate");
    run_grants(1'b1, "RRRRWR", "urgent_streak");

    // Reset in the middle of a 64-beat read; remaining data still forwarded
    do_reset();
    bus.rd_address    = 28'h0200000;
    bus.rd_burstcount = 8'd64;
    bus.rd_read       = 1'b1;
    step();
    step();
    bus.rd_read = 1'b0;
    bus.vbuf_readdatavalid = 1'b1;
    repeat (10) step();
    bus.wr_write         = 1'b1;
    bus.vbuf_waitrequest = 1'b1;
    reset_n              = 1'b0;
    fwd = 0; bad = 0;
    half();
    chk1("rst_rdv_fwd_in_reset", bus.rd_readdatavalid, 1'b1);
    if (bus.rd_readdatavalid) fwd++;
    step();
    reset_n = 1'b1;
    half();
    chk1("rst_idle_read", bus.vbuf_read, 1'b0);
    chk1("rst_idle_write", bus.vbuf_write, 1'b0);
    chk1("rst_idle_grant_rd", bus.grant_rd, 1'b0);
    chk1("rst_idle_grant_wr", bus.grant_wr, 1'b0);
    if (bus.rd_readdatavalid) fwd++;
    step();
    half();
    chk1("rst_wr_grant", bus.grant_wr, 1'b1);
    if (bus.rd_readdatavalid) fwd++;
    step();
    for (int c = 0; c < 51; c++) begin
      half();
      if (bus.rd_readdatavalid) fwd++;
      if (bus.grant_rd) bad++;
      step();
    end
    bus.vbuf_readdatavalid = 1'b0;
    chkw("rst_remaining_fwd", fwd, 54);
    chkw("rst_stray_rd_grant", bad, 0);
    bus.vbuf_waitrequest = 1'b0;
    half();
    chk1("rst_wr_beat", bus.vbuf_write, 1'b1);
    step();
    bus.wr_write = 1'b0;
    half();
    chk1("rst_wr_done", bus.grant_wr, 1'b0);
    step();

    // DDR stall of 20 cycles on a read command with a write pending
    do_reset();
    bus.rd_address       = 28'h0ABCDEF;
    bus.rd_burstcount    = 8'd16;
    bus.rd_read          = 1'b1;
    bus.wr_write         = 1'b1;
    bus.vbuf_waitrequest = 1'b1;
    step();
    bad = 0;
    for (int c = 0; c < 20; c++) begin
      half();
      if (!bus.vbuf_read || bus.vbuf_write) bad++;
      if (bus.vbuf_address !== 28'h0ABCDEF || bus.vbuf_burstcount !== 8'd16) bad++;
      if (!bus.rd_waitrequest || !bus.wr_waitrequest) bad++;
      step();
    end
    chkw("stall_stable_errs", bad, 0);
    bus.vbuf_waitrequest = 1'b0;
    half();
    chk1("stall_release_rd_wait", bus.rd_waitrequest, 1'b0);
    chk1("stall_release_wr_wait", bus.wr_waitrequest, 1'b1);
    step();
    bus.rd_read = 1'b0;
    bus.vbuf_readdatavalid = 1'b1;
    repeat (15) step();
    half();
    chk1("stall_last_beat_grant", bus.grant_rd, 1'b1);
    step();
    bus.vbuf_readdatavalid = 1'b0;
    half();
    chk1("stall_done_grant", bus.grant_rd, 1'b0);
    step();
    bus.wr_write = 1'b0;
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
